// File: rtl/prism_in_filter_pkg.sv
// Shared constants for the prism_in_filter input qualifier.
// Flag behaviour is selected by the PRISM_IN_FILTER_FLAGS_EN macro in the top.
package prism_in_filter_pkg;

    localparam int NUM_IN_DEF = 8;
    localparam int CNT_W_DEF  = 4;
    localparam int PRE_W_DEF  = 8;

    // When a flag sees a set and a clear on the same edge, the set is kept.
    localparam bit FLAG_SET_WINS = 1'b1;
    localparam bit FLAG_CLR_WINS = ~FLAG_SET_WINS;

endpackage

// File: rtl/prism_in_filter_if.sv
// Signal bundle between the pin-side driver and the prism_in_filter block.
// No valid/ready handshake: every signal is a level, sampled on each rising clk edge.
interface prism_in_filter_if
    import prism_in_filter_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PRE_W  = PRE_W_DEF
);
    logic [NUM_IN-1:0] in_raw;
    logic [NUM_IN-1:0] filt_mask;
    logic [CNT_W-1:0]  filt_len;
    logic [PRE_W-1:0]  prescale;
    logic [NUM_IN-1:0] flag_rise_en;
    logic [NUM_IN-1:0] flag_fall_en;
    logic [NUM_IN-1:0] flag_clr;
    logic [NUM_IN-1:0] in_filt;
    logic [NUM_IN-1:0] rise;
    logic [NUM_IN-1:0] fall;
    logic [NUM_IN-1:0] edge_flags;
    logic              irq;

    modport master (
        output in_raw, filt_mask, filt_len, prescale,
        output flag_rise_en, flag_fall_en, flag_clr,
        input  in_filt, rise, fall, edge_flags, irq
    );

    modport slave (
        input  in_raw, filt_mask, filt_len, prescale,
        input  flag_rise_en, flag_fall_en, flag_clr,
        output in_filt, rise, fall, edge_flags, irq
    );
endinterface

// File: rtl/prism_in_filter_bit.sv
// One qualified input bit: stability counter, clean level and edge pulses.
module prism_in_filter_bit #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             mask,
    input  logic [CNT_W-1:0] len,
    input  logic             raw,
    output logic             in_filt,
    output logic             rise,
    output logic             fall
);
    logic [CNT_W-1:0] cnt;

    // The >= compare lets a shrinking len take effect on the next tick and
    // keeps cnt from ever incrementing past len.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            in_filt <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (raw == in_filt) begin
                cnt <= '0;
            end else if (!mask || (tick && cnt >= len)) begin
                in_filt <= raw;
                rise    <= raw;
                fall    <= ~raw;
                cnt     <= '0;
            end else if (tick) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/prism_in_filter.sv
// Per-bit glitch filter with prescaled stability counting, edge pulses and
// optional sticky edge flags + irq (enabled by defining PRISM_IN_FILTER_FLAGS_EN).
module prism_in_filter
    import prism_in_filter_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PRE_W  = PRE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    prism_in_filter_if.slave  bus
);
    logic [PRE_W-1:0]  pre_cnt;
    logic              tick;
    logic [NUM_IN-1:0] filt_v;
    logic [NUM_IN-1:0] rise_v;
    logic [NUM_IN-1:0] fall_v;

    // Lowering prescale below pre_cnt still produces a tick and a wrap.
    assign tick = (pre_cnt >= bus.prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : g_bit
        prism_in_filter_bit #(
            .CNT_W (CNT_W)
        ) u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick),
            .mask    (bus.filt_mask[i]),
            .len     (bus.filt_len),
            .raw     (bus.in_raw[i]),
            .in_filt (filt_v[i]),
            .rise    (rise_v[i]),
            .fall    (fall_v[i])
        );
    end

    assign bus.in_filt = filt_v;
    assign bus.rise    = rise_v;
    assign bus.fall    = fall_v;

`ifdef PRISM_IN_FILTER_FLAGS_EN
    logic [NUM_IN-1:0] flags;
    logic [NUM_IN-1:0] flag_set;

    assign flag_set = (rise_v & bus.flag_rise_en) | (fall_v & bus.flag_fall_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= '0;
        end else if (FLAG_CLR_WINS) begin
            flags <= (flags | flag_set) & ~bus.flag_clr;
        end else begin
            flags <= flag_set | (flags & ~bus.flag_clr);
        end
    end

    assign bus.edge_flags = flags;
    assign bus.irq        = |flags;
`else
    logic unused_flag_inputs;

    assign unused_flag_inputs = ^{bus.flag_rise_en, bus.flag_fall_en, bus.flag_clr};
    assign bus.edge_flags     = '0;
    assign bus.irq            = 1'b0;
`endif
endmodule
